pong_renderer: RTL and testbench
================================

Name: pong_renderer

Overview:
- Pixel source for the DVI output path: takes the current raster coordinate from the display sync and returns the RGB colour for the Pong scene (two paddles, ball, optional centre net).
- Output is registered with exactly 1 cycle latency, matching the 1-cycle sync/DE delay in the DVI top.
- Game logic pushes object positions through a valid/ready port. Positions are double-buffered and committed only at the start of vertical blanking, so no tearing occurs.

Parameters:
- PADDLE_W, 8, paddle width in pixels
- PADDLE_H, 64, paddle height in pixels
- PADDLE_X_OFF, 16, gap between screen edge and paddle outer edge
- BALL_SIZE, 8, ball side length (square)
- NET_W, 4, centre net width (used only with the optional feature)

Ports:
- clk_i  in  1  pixel clock
- rst_ni  in  1  asynchronous reset, active-low
- x_i  in  X_POS_W  current raster x from sync
- y_i  in  Y_POS_W  current raster y from sync
- upd_valid_i  in  1  new position set offered
- upd_ready_o  out  1  block can accept a position set
- paddle_l_y_i  in  Y_POS_W  left paddle top y
- paddle_r_y_i  in  Y_POS_W  right paddle top y
- ball_x_i  in  X_POS_W  ball left x
- ball_y_i  in  Y_POS_W  ball top y
- red_o, green_o, blue_o  out  COLOR_W each  pixel colour, 1-cycle latency
- frame_tick_o  out  1  one-cycle pulse on each commit point

Behaviour:
- Reset (async assert, sync release):
  - colours = 0, upd_ready_o = 1, frame_tick_o = 0, pending = 0.
  - Active and shadow positions reset to: paddles at (V_VISIBLE-PADDLE_H)/2; ball at ((H_VISIBLE-BALL_SIZE)/2, (V_VISIBLE-BALL_SIZE)/2).
- Handshake:
  - A transfer occurs when upd_valid_i && upd_ready_o; the four position inputs are latched into the shadow registers and pending is set.
  - upd_ready_o = !pending, registered from the pending flop.
  - Inputs are don't-care when no transfer occurs. The producer may hold valid high indefinitely.
- Commit point: the cycle where x_i == 0 && y_i == V_VISIBLE (first pixel of vertical blanking).
  - frame_tick_o pulses next cycle, whether or not pending is set.
  - If pending: shadow copies to active, pending clears, upd_ready_o returns 1 the following cycle.
  - A transfer cannot coincide with a commit, because ready is low while pending.
  - If nothing is pending, the active set is unchanged.
- Hit tests (combinational on x_i/y_i vs active set, half-open ranges). Compare with one extra bit of width so that obj + size never wraps; objects near the bottom/right edge clip, never alias to the top.
  - left paddle: x in [PADDLE_X_OFF, PADDLE_X_OFF+PADDLE_W), y in [pl_y, pl_y+PADDLE_H)
  - right paddle: x in [H_VISIBLE-PADDLE_X_OFF-PADDLE_W, H_VISIBLE-PADDLE_X_OFF), y in [pr_y, pr_y+PADDLE_H)
  - ball: x in [bx, bx+BALL_SIZE), y in [by, by+BALL_SIZE)
- Colour select, registered:
  - outside visible area (x_i >= H_VISIBLE or y_i >= V_VISIBLE): COLOR_BG
  - otherwise priority ball (COLOR_BALL) > paddles (COLOR_FG) > net (COLOR_FG) > COLOR_BG
- Reset mid-frame: outputs go to 0 immediately and any pending update is discarded.

Optional Feature:
- Macro PONG_RENDER_NET_EN.
- Defined: dashed centre net drawn at x in [H_VISIBLE/2-NET_W/2, H_VISIBLE/2+NET_W/2) on lines where y_i[4] == 0 (16-line dash / 16-line gap).
- Undefined: net logic absent; those pixels show background.

Decomposition:
- display_pkg: H_VISIBLE, V_VISIBLE, X_POS_W, Y_POS_W, COLOR_W.
- pong_pkg: typedef pong_pos_t (struct: paddle_l_y, paddle_r_y, ball_x, ball_y); localparams COLOR_FG, COLOR_BG, COLOR_BALL as 3×COLOR_W RGB triples.
- Sub-module rect_hit (purely combinational): inputs point, rectangle origin and size; output inside flag. Instantiated 3 times.

Test Plan (640x480, COLOR_W = 8):
- Reset release, raster at (100,100) -> RGB 0 for that cycle, then background; upd_ready_o = 1; active ball at (316,236).
- Push ball (50,60), raster passes (52,62) before the commit -> ball colour not shown (old set). At (0,480): frame_tick_o pulses; next frame (52,62) -> COLOR_BALL exactly 1 cycle after x_i/y_i present it.
- Two valid pulses before the commit -> second is held off (upd_ready_o = 0) until the cycle after the commit; second set visible one frame later.
- Ball at (16,100) overlapping left paddle at y = 80; sample (20,104) -> COLOR_BALL (priority); (20,140) -> COLOR_FG.
- Paddle y = 470 -> pixels y 470..479 are FG; line 0 at x = 20 is BG (no wrap); (20,480) -> BG.
- With PONG_RENDER_NET_EN: (319,5) -> FG, (319,20) -> BG. Without the macro: (319,5) -> BG.

Source files
------------

// File: rtl/display_pkg.sv
// Display timing constants shared by the sync generator, DVI top and pixel sources.
package display_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int X_POS_W   = 10;
    localparam int Y_POS_W   = 10;
    localparam int COLOR_W   = 8;

endpackage : display_pkg

// File: rtl/pong_pkg.sv
// Pong scene geometry, colour palette and the position-set type pushed by game logic.
package pong_pkg;

    import display_pkg::*;

    localparam int PADDLE_W     = 8;
    localparam int PADDLE_H     = 64;
    localparam int PADDLE_X_OFF = 16;
    localparam int BALL_SIZE    = 8;
    localparam int NET_W        = 4;

    // RGB triples packed as {red, green, blue}.
    localparam logic [3*COLOR_W-1:0] COLOR_FG   = {8'hFF, 8'hFF, 8'hFF};
    localparam logic [3*COLOR_W-1:0] COLOR_BG   = {8'h00, 8'h00, 8'h40};
    localparam logic [3*COLOR_W-1:0] COLOR_BALL = {8'hFF, 8'hFF, 8'h00};

    typedef struct packed {
        logic [Y_POS_W-1:0] paddle_l_y;
        logic [Y_POS_W-1:0] paddle_r_y;
        logic [X_POS_W-1:0] ball_x;
        logic [Y_POS_W-1:0] ball_y;
    } pong_pos_t;

    // Paddles vertically centred, ball in the middle of the visible area.
    localparam pong_pos_t POS_RESET = '{
        paddle_l_y: Y_POS_W'((V_VISIBLE - PADDLE_H) / 2),
        paddle_r_y: Y_POS_W'((V_VISIBLE - PADDLE_H) / 2),
        ball_x:     X_POS_W'((H_VISIBLE - BALL_SIZE) / 2),
        ball_y:     Y_POS_W'((V_VISIBLE - BALL_SIZE) / 2)
    };

endpackage : pong_pkg

// File: rtl/rect_hit.sv
// Combinational point-in-rectangle test over half-open ranges [origin, origin+size).
// The end coordinate carries one extra bit so objects at the right/bottom edge clip
// instead of wrapping back to coordinate 0.
module rect_hit
    import display_pkg::*;
#(
    parameter int XW = X_POS_W,
    parameter int YW = Y_POS_W
) (
    input  logic [XW-1:0] px_i,
    input  logic [YW-1:0] py_i,
    input  logic [XW-1:0] ox_i,
    input  logic [YW-1:0] oy_i,
    input  logic [XW-1:0] w_i,
    input  logic [YW-1:0] h_i,
    output logic          inside_o
);

    logic [XW:0] x_end;
    logic [YW:0] y_end;

    assign x_end = {1'b0, ox_i} + {1'b0, w_i};
    assign y_end = {1'b0, oy_i} + {1'b0, h_i};

    assign inside_o = (px_i >= ox_i) && ({1'b0, px_i} < x_end) &&
                      (py_i >= oy_i) && ({1'b0, py_i} < y_end);

endmodule : rect_hit

// File: rtl/pong_renderer.sv
// Pong scene pixel source: maps the raster coordinate to an RGB colour with one cycle
// of latency. Object positions arrive over a valid/ready port into a shadow set that
// is committed to the active set at the first pixel of vertical blanking.
// Optional build macro: PONG_RENDER_NET_EN draws a dashed centre net.
module pong_renderer
    import display_pkg::*;
    import pong_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [X_POS_W-1:0] x_i,
    input  logic [Y_POS_W-1:0] y_i,
    input  logic               upd_valid_i,
    output logic               upd_ready_o,
    input  logic [Y_POS_W-1:0] paddle_l_y_i,
    input  logic [Y_POS_W-1:0] paddle_r_y_i,
    input  logic [X_POS_W-1:0] ball_x_i,
    input  logic [Y_POS_W-1:0] ball_y_i,
    output logic [COLOR_W-1:0] red_o,
    output logic [COLOR_W-1:0] green_o,
    output logic [COLOR_W-1:0] blue_o,
    output logic               frame_tick_o
);

    localparam logic [X_POS_W-1:0] H_VIS    = X_POS_W'(H_VISIBLE);
    localparam logic [Y_POS_W-1:0] V_VIS    = Y_POS_W'(V_VISIBLE);
    localparam logic [X_POS_W-1:0] PL_X     = X_POS_W'(PADDLE_X_OFF);
    localparam logic [X_POS_W-1:0] PR_X     = X_POS_W'(H_VISIBLE - PADDLE_X_OFF - PADDLE_W);
    localparam logic [X_POS_W-1:0] PAD_W    = X_POS_W'(PADDLE_W);
    localparam logic [Y_POS_W-1:0] PAD_H    = Y_POS_W'(PADDLE_H);
    localparam logic [X_POS_W-1:0] BALL_W_X = X_POS_W'(BALL_SIZE);
    localparam logic [Y_POS_W-1:0] BALL_H_Y = Y_POS_W'(BALL_SIZE);

    pong_pos_t              active_q, active_d;
    pong_pos_t              shadow_q, shadow_d;
    logic                   pending_q, pending_d;
    logic                   ready_q, ready_d;
    logic                   tick_q, tick_d;
    logic [3*COLOR_W-1:0]   rgb_q, rgb_d;

    logic transfer, commit, visible;
    logic hit_pl, hit_pr, hit_ball, hit_net;

    assign transfer = upd_valid_i && ready_q;
    assign commit   = (x_i == '0) && (y_i == V_VIS);
    assign visible  = (x_i < H_VIS) && (y_i < V_VIS);

    rect_hit u_hit_pl (
        .px_i(x_i), .py_i(y_i), .ox_i(PL_X), .oy_i(active_q.paddle_l_y),
        .w_i(PAD_W), .h_i(PAD_H), .inside_o(hit_pl)
    );

    rect_hit u_hit_pr (
        .px_i(x_i), .py_i(y_i), .ox_i(PR_X), .oy_i(active_q.paddle_r_y),
        .w_i(PAD_W), .h_i(PAD_H), .inside_o(hit_pr)
    );

    rect_hit u_hit_ball (
        .px_i(x_i), .py_i(y_i), .ox_i(active_q.ball_x), .oy_i(active_q.ball_y),
        .w_i(BALL_W_X), .h_i(BALL_H_Y), .inside_o(hit_ball)
    );

`ifdef PONG_RENDER_NET_EN
    localparam logic [X_POS_W-1:0] NET_X0 = X_POS_W'(H_VISIBLE / 2 - NET_W / 2);
    localparam logic [X_POS_W-1:0] NET_X1 = X_POS_W'(H_VISIBLE / 2 + NET_W / 2);
    // 16-line dash / 16-line gap.
    assign hit_net = (x_i >= NET_X0) && (x_i < NET_X1) && !y_i[4];
`else
    assign hit_net = 1'b0;
`endif

    // Next-state for the handshake, double-buffered position sets and pixel colour.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        tick_d    = commit;
        rgb_d     = COLOR_BG;

        // Ready is low while pending, so a transfer and a commit never share a cycle.
        if (transfer) begin
            shadow_d = '{paddle_l_y: paddle_l_y_i, paddle_r_y: paddle_r_y_i,
                         ball_x: ball_x_i, ball_y: ball_y_i};
            pending_d = 1'b1;
        end else if (commit && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        ready_d = !pending_d;

        if (visible) begin
            if (hit_ball) begin
                rgb_d = COLOR_BALL;
            end else if (hit_pl || hit_pr || hit_net) begin
                rgb_d = COLOR_FG;
            end
        end
    end

    // State and output registers; reset discards any pending update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the position registers are reset too, so the first frame shows a defined scene.
            active_q  <= POS_RESET;
            shadow_q  <= POS_RESET;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            tick_q    <= 1'b0;
            rgb_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            tick_q    <= tick_d;
            rgb_q     <= rgb_d;
        end
    end

    assign upd_ready_o  = ready_q;
    assign frame_tick_o = tick_q;
    assign red_o        = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign green_o      = rgb_q[2*COLOR_W-1:COLOR_W];
    assign blue_o       = rgb_q[COLOR_W-1:0];

endmodule : pong_renderer

// File: tb/tb_pong_renderer.sv
// Scoreboard bench for pong_renderer (640x480, 8-bit colour). Stimulus tasks drive one
// raster coordinate per cycle and queue the expected registered response; a monitor
// pops and compares one cycle later.
module tb_pong_renderer;

    localparam logic [23:0] C_BG   = 24'h000040;
    localparam logic [23:0] C_FG   = 24'hFFFFFF;
    localparam logic [23:0] C_BALL = 24'hFFFF00;
`ifdef PONG_RENDER_NET_EN
    localparam logic [23:0] C_NET  = C_FG;
`else
    localparam logic [23:0] C_NET  = C_BG;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] x = 10'd100, y = 10'd100;
    logic       valid = 1'b0;
    logic [9:0] pl = '0, pr = '0, bx = '0, by = '0;
    logic       ready, tick;
    logic [7:0] red, green, blue;

    pong_renderer dut (
        .clk_i(clk), .rst_ni(rst_n), .x_i(x), .y_i(y),
        .upd_valid_i(valid), .upd_ready_o(ready),
        .paddle_l_y_i(pl), .paddle_r_y_i(pr), .ball_x_i(bx), .ball_y_i(by),
        .red_o(red), .green_o(green), .blue_o(blue), .frame_tick_o(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [23:0] rgb;
        bit          c_rdy;
        logic        rdy;
        logic        tck;
    } exp_t;

    exp_t sb[$];
    bit   req = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle and queue what the outputs must show after its rising edge.
    task automatic cyc(input string name, input int cx, input int cy, input bit v,
                       input logic [23:0] rgb, input logic tck, input bit c_rdy, input logic rdy);
        exp_t e;
        @(negedge clk);
        x = 10'(cx);
        y = 10'(cy);
        valid = v;
        e.name = name; e.rgb = rgb; e.tck = tck; e.c_rdy = c_rdy; e.rdy = rdy;
        sb.push_back(e);
        req = 1'b1;
    endtask

    task automatic px(input string name, input int cx, input int cy, input logic [23:0] rgb);
        cyc(name, cx, cy, 1'b0, rgb, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic offer(input string name, input int cx, input int cy, input logic [23:0] rgb,
                         input logic rdy);
        cyc(name, cx, cy, 1'b1, rgb, 1'b0, 1'b1, rdy);
    endtask

    task automatic commit(input string name, input bit v, input logic rdy);
        cyc(name, 0, 480, v, C_BG, 1'b1, 1'b1, rdy);
    endtask

    task automatic set_pos(input int l, input int r, input int ballx, input int bally);
        pl = 10'(l); pr = 10'(r); bx = 10'(ballx); by = 10'(bally);
    endtask

    task automatic idle();
        @(negedge clk);
        req = 1'b0;
        valid = 1'b0;
    endtask

    // Monitor: compare the registered outputs against the queued expectation.
    initial begin
        bit   r;
        exp_t e;
        forever begin
            @(posedge clk);
            r = req;
            #1;
            if (r) begin
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard_underflow: no expectation queued");
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_rgb"}, {8'h00, red, green, blue}, {8'h00, e.rgb});
                    check({e.name, "_tick"}, {31'd0, tick}, {31'd0, e.tck});
                    if (e.c_rdy) check({e.name, "_ready"}, {31'd0, ready}, {31'd0, e.rdy});
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_rgb", {8'h00, red, green, blue}, 32'h0);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_tick", {31'd0, tick}, 32'd0);

        // Reset scene: paddles at y=208, ball at (316,236).
        px("bg_100_100", 100, 100, C_BG);
        px("reset_ball", 316, 236, C_BALL);
        px("reset_ball_end", 324, 236, C_BG);
        px("reset_pl", 20, 208, C_FG);
        px("reset_pr", 620, 260, C_FG);
        px("pr_right_edge", 624, 260, C_BG);
        px("offscreen_x", 700, 100, C_BG);
        px("net_on", 319, 5, C_NET);
        px("net_gap", 319, 20, C_BG);

        // First set accepted, second held off until the cycle after the commit.
        set_pos(208, 208, 50, 60);
        offer("push1", 52, 62, C_BG, 1'b0);
        px("old_set", 52, 62, C_BG);
        set_pos(208, 208, 200, 300);
        offer("push2_held", 10, 10, C_BG, 1'b0);
        commit("commit1", 1'b1, 1'b1);
        offer("push2_acc", 52, 62, C_BALL, 1'b0);
        px("set2_not_yet", 200, 300, C_BG);
        px("set1_px", 53, 63, C_BALL);
        commit("commit2", 1'b0, 1'b1);
        px("set2_vis", 200, 300, C_BALL);
        px("set1_gone", 52, 62, C_BG);

        // Ball over the left paddle: ball wins.
        set_pos(80, 208, 16, 100);
        offer("push3", 100, 100, C_BG, 1'b0);
        commit("commit3", 1'b0, 1'b1);
        px("ball_prio", 20, 104, C_BALL);
        px("paddle_fg", 20, 140, C_FG);
        px("paddle_gap", 30, 104, C_BG);

        // Paddle clipped at the bottom edge, no wrap to the top.
        set_pos(470, 208, 316, 236);
        offer("push4", 100, 100, C_BG, 1'b0);
        commit("commit4", 1'b0, 1'b1);
        px("clip_470", 20, 470, C_FG);
        px("clip_479", 20, 479, C_FG);
        px("clip_469", 20, 469, C_BG);
        px("nowrap_0", 20, 0, C_BG);
        px("below_vis", 20, 480, C_BG);

        // Commit with nothing pending still ticks; active set unchanged.
        commit("commit_idle", 1'b0, 1'b1);
        px("after_idle_tick", 20, 470, C_FG);

        // Mid-frame reset discards the pending set.
        set_pos(208, 208, 400, 400);
        offer("push5", 100, 100, C_BG, 1'b0);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("midreset_rgb", {8'h00, red, green, blue}, 32'h0);
        check("midreset_ready", {31'd0, ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        commit("commit_post_rst", 1'b0, 1'b1);
        px("discarded_ball", 400, 400, C_BG);
        px("default_ball", 316, 236, C_BALL);
        px("default_pl", 20, 208, C_FG);

        idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pong_renderer
